sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for same-domain buffering between subsystem blocks, such as the register file to the TX serializer path. It is the same-clock successor of the dual-clock FIFO and uses binary pointers, with no gray coding and no synchronisers. It adds the following over the dual-clock FIFO:
- programmable almost-full / almost-empty thresholds
- an occupancy count
- registered read data with a valid strobe
- synchronous flush
- sticky overflow/underflow error flags

---
 rtl/sync_fifo_if.sv | 33 +++
 rtl/sync_fifo.sv | 140 ++++++++++++++
 tb/tb_sync_fifo.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Handshake bundle between a producer/consumer pair and the single-clock FIFO.
// The master modport drives requests and observes status; the slave is the FIFO side.
interface sync_fifo_if #(
  parameter int D_SIZE = 16,
  parameter int P_SIZE = 4
);
  logic              i_w_inc;
  logic [D_SIZE-1:0] i_w_data;
  logic              i_r_inc;
  logic              i_flush;
  logic              i_clr_err;
  logic [D_SIZE-1:0] o_r_data;
  logic              o_r_valid;
  logic              o_full;
  logic              o_empty;
  logic              o_almost_full;
  logic              o_almost_empty;
  logic [P_SIZE-1:0] o_count;
  logic              o_overflow;
  logic              o_underflow;

  modport master (
    output i_w_inc, i_w_data, i_r_inc, i_flush, i_clr_err,
    input  o_r_data, o_r_valid, o_full, o_empty, o_almost_full,
           o_almost_empty, o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_w_inc, i_w_data, i_r_inc, i_flush, i_clr_err,
    output o_r_data, o_r_valid, o_full, o_empty, o_almost_full,
           o_almost_empty, o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with binary pointers, occupancy count, registered read data,
// synchronous flush and sticky overflow/underflow flags. All status outputs are registers.
module sync_fifo #(
  parameter int D_SIZE    = 16,
  parameter int F_DEPTH   = 8,
  parameter int P_SIZE    = 4,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic     i_clk,
  input  logic     i_rstn,
  sync_fifo_if.slave fifo
);
  localparam int A_SIZE = P_SIZE - 1;

  logic [D_SIZE-1:0] mem_r [F_DEPTH];
  logic [P_SIZE-1:0] wptr_r, rptr_r, count_r;
  logic [D_SIZE-1:0] r_data_r;
  logic              r_valid_r;
  logic              full_r, empty_r, almost_full_r, almost_empty_r;
  logic              overflow_r, underflow_r;

  logic              w_acc_s, r_acc_s;
  logic [P_SIZE-1:0] wptr_nxt_s, rptr_nxt_s, count_nxt_s;
  logic              full_nxt_s, empty_nxt_s, almost_full_nxt_s, almost_empty_nxt_s;
  logic              overflow_nxt_s, underflow_nxt_s;

  // Accept decisions and next-state of pointers, count, flags and error bits
  always_comb begin
    w_acc_s            = fifo.i_w_inc && !full_r  && !fifo.i_flush;
    r_acc_s            = fifo.i_r_inc && !empty_r && !fifo.i_flush;
    wptr_nxt_s         = wptr_r;
    rptr_nxt_s         = rptr_r;
    count_nxt_s        = count_r;
    overflow_nxt_s     = overflow_r;
    underflow_nxt_s    = underflow_r;

    if (fifo.i_flush) begin
      wptr_nxt_s  = {P_SIZE{1'b0}};
      rptr_nxt_s  = {P_SIZE{1'b0}};
      count_nxt_s = {P_SIZE{1'b0}};
    end else begin
      if (w_acc_s) begin
        wptr_nxt_s = wptr_r + P_SIZE'(1);
      end else begin
        wptr_nxt_s = wptr_r;
      end
      if (r_acc_s) begin
        rptr_nxt_s = rptr_r + P_SIZE'(1);
      end else begin
        rptr_nxt_s = rptr_r;
      end
      case ({w_acc_s, r_acc_s})
        2'b10:   count_nxt_s = count_r + P_SIZE'(1);
        2'b01:   count_nxt_s = count_r - P_SIZE'(1);
        default: count_nxt_s = count_r;
      endcase
    end

    // Full: same address bits, opposite wrap bit; empty: pointers identical
    full_nxt_s  = (wptr_nxt_s[A_SIZE-1:0] == rptr_nxt_s[A_SIZE-1:0]) &&
                  (wptr_nxt_s[A_SIZE] != rptr_nxt_s[A_SIZE]);
    empty_nxt_s = (wptr_nxt_s == rptr_nxt_s);
    almost_full_nxt_s  = (count_nxt_s >= P_SIZE'(AF_THRESH));
    almost_empty_nxt_s = (count_nxt_s <= P_SIZE'(AE_THRESH));

    // Set has priority over clear so a rejection on the clearing edge is not lost
    if (fifo.i_w_inc && full_r && !fifo.i_flush) begin
      overflow_nxt_s = 1'b1;
    end else if (fifo.i_clr_err) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r;
    end
    if (fifo.i_r_inc && empty_r && !fifo.i_flush) begin
      underflow_nxt_s = 1'b1;
    end else if (fifo.i_clr_err) begin
      underflow_nxt_s = 1'b0;
    end else begin
      underflow_nxt_s = underflow_r;
    end
  end

  // Storage array; contents are deliberately left unreset
  always_ff @(posedge i_clk) begin
    if (w_acc_s) begin
      mem_r[wptr_r[A_SIZE-1:0]] <= fifo.i_w_data;
    end
  end

  // Control and status state
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr_r         <= {P_SIZE{1'b0}};
      rptr_r         <= {P_SIZE{1'b0}};
      count_r        <= {P_SIZE{1'b0}};
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
    end else begin
      wptr_r         <= wptr_nxt_s;
      rptr_r         <= rptr_nxt_s;
      count_r        <= count_nxt_s;
      full_r         <= full_nxt_s;
      empty_r        <= empty_nxt_s;
      almost_full_r  <= almost_full_nxt_s;
      almost_empty_r <= almost_empty_nxt_s;
      overflow_r     <= overflow_nxt_s;
      underflow_r    <= underflow_nxt_s;
    end
  end

  // Read data register and its one-cycle valid strobe
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_data_r  <= {D_SIZE{1'b0}};
      r_valid_r <= 1'b0;
    end else begin
      r_valid_r <= r_acc_s;
      if (r_acc_s) begin
        r_data_r <= mem_r[rptr_r[A_SIZE-1:0]];
      end else begin
        r_data_r <= r_data_r;
      end
    end
  end

  assign fifo.o_r_data       = r_data_r;
  assign fifo.o_r_valid      = r_valid_r;
  assign fifo.o_full         = full_r;
  assign fifo.o_empty        = empty_r;
  assign fifo.o_almost_full  = almost_full_r;
  assign fifo.o_almost_empty = almost_empty_r;
  assign fifo.o_count        = count_r;
  assign fifo.o_overflow     = overflow_r;
  assign fifo.o_underflow    = underflow_r;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo: fill/drain, errors, wrap, boundary
// simultaneity, flush and asynchronous reset.
module tb_sync_fifo;
  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_bad;

  sync_fifo_if #(.D_SIZE(16), .P_SIZE(4)) fif ();

  sync_fifo #(
    .D_SIZE(16), .F_DEPTH(8), .P_SIZE(4), .AF_THRESH(6), .AE_THRESH(2)
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .fifo  (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given requests; returns 1 time unit after the edge
  task automatic cyc(input logic w, input logic [15:0] wd, input logic r,
                     input logic fl, input logic ce);
    fif.i_w_inc   = w;
    fif.i_w_data  = wd;
    fif.i_r_inc   = r;
    fif.i_flush   = fl;
    fif.i_clr_err = ce;
    @(posedge clk);
    #1;
    fif.i_w_inc   = 1'b0;
    fif.i_r_inc   = 1'b0;
    fif.i_flush   = 1'b0;
    fif.i_clr_err = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn = 1'b0;
    fif.i_w_inc = 1'b0; fif.i_w_data = 16'h0000; fif.i_r_inc = 1'b0;
    fif.i_flush = 1'b0; fif.i_clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(fif.o_count), 32'd0);
    check("rst_empty", 32'(fif.o_empty), 32'd1);
    check("rst_full",  32'(fif.o_full), 32'd0);
    check("rst_ae",    32'(fif.o_almost_empty), 32'd1);
    check("rst_af",    32'(fif.o_almost_full), 32'd0);
    check("rst_rdata", 32'(fif.o_r_data), 32'd0);
    check("rst_rvalid", 32'(fif.o_r_valid), 32'd0);
    check("rst_ovf",   32'(fif.o_overflow), 32'd0);
    check("rst_unf",   32'(fif.o_underflow), 32'd0);
    rstn = 1'b1;

    // Fill with 1..8 and watch thresholds
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      check("fill_count", 32'(fif.o_count), 32'(i));
      check("fill_af", 32'(fif.o_almost_full), (i >= 6) ? 32'd1 : 32'd0);
      check("fill_ae", 32'(fif.o_almost_empty), (i <= 2) ? 32'd1 : 32'd0);
      check("fill_full", 32'(fif.o_full), (i == 8) ? 32'd1 : 32'd0);
    end

    // Drain in order with valid strobes
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      check("drain_valid", 32'(fif.o_r_valid), 32'd1);
      check("drain_data", 32'(fif.o_r_data), 32'(i));
      check("drain_count", 32'(fif.o_count), 32'(8 - i));
    end
    check("drain_empty", 32'(fif.o_empty), 32'd1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("idle_valid", 32'(fif.o_r_valid), 32'd0);
    check("idle_hold", 32'(fif.o_r_data), 32'h0008);

    // Overflow, set-wins-over-clear, clear, then underflow
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h0011 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    check("ovf_set", 32'(fif.o_overflow), 32'd1);
    check("ovf_count", 32'(fif.o_count), 32'd8);
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
    check("ovf_set_wins", 32'(fif.o_overflow), 32'd1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", 32'(fif.o_overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      check("ovf_data", 32'(fif.o_r_data), 32'(16'h0011 + i));
    end
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("unf_set", 32'(fif.o_underflow), 32'd1);
    check("unf_valid", 32'(fif.o_r_valid), 32'd0);
    check("unf_hold", 32'(fif.o_r_data), 32'h0018);
    check("unf_count", 32'(fif.o_count), 32'd0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("unf_clr", 32'(fif.o_underflow), 32'd0);

    // Steady-state streaming at count 4 across pointer wrap
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 16'(16'h0104 + k), 1'b1, 1'b0, 1'b0);
      check("stream_count", 32'(fif.o_count), 32'd4);
      check("stream_data", 32'(fif.o_r_data), 32'(16'h0100 + k));
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      check("stream_tail", 32'(fif.o_r_data), 32'(16'h0114 + i));
    end
    check("stream_empty", 32'(fif.o_empty), 32'd1);

    // Full with write+read: read wins, write dropped
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    check("fwr_count", 32'(fif.o_count), 32'd7);
    check("fwr_data", 32'(fif.o_r_data), 32'h0200);
    check("fwr_valid", 32'(fif.o_r_valid), 32'd1);
    check("fwr_ovf", 32'(fif.o_overflow), 32'd1);
    check("fwr_full", 32'(fif.o_full), 32'd0);
    for (int i = 1; i < 8; i++) begin
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      check("fwr_drain", 32'(fif.o_r_data), 32'(16'h0200 + i));
    end
    check("fwr_empty", 32'(fif.o_empty), 32'd1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Empty with write+read: write wins, no fall-through
    cyc(1'b1, 16'h0300, 1'b1, 1'b0, 1'b0);
    check("ewr_count", 32'(fif.o_count), 32'd1);
    check("ewr_valid", 32'(fif.o_r_valid), 32'd0);
    check("ewr_unf", 32'(fif.o_underflow), 32'd1);
    check("ewr_empty", 32'(fif.o_empty), 32'd0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    check("ewr_data", 32'(fif.o_r_data), 32'h0300);
    check("ewr_clr", 32'(fif.o_underflow), 32'd0);

    // Flush at count 5 with a concurrent write
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h0400 + i), 1'b0, 1'b0, 1'b0);
    check("pre_flush", 32'(fif.o_count), 32'd5);
    cyc(1'b1, 16'h0EEE, 1'b1, 1'b1, 1'b0);
    check("flush_count", 32'(fif.o_count), 32'd0);
    check("flush_empty", 32'(fif.o_empty), 32'd1);
    check("flush_ae", 32'(fif.o_almost_empty), 32'd1);
    check("flush_valid", 32'(fif.o_r_valid), 32'd0);
    check("flush_hold", 32'(fif.o_r_data), 32'h0300);
    check("flush_ovf", 32'(fif.o_overflow), 32'd0);
    check("flush_unf", 32'(fif.o_underflow), 32'd0);

    // Asynchronous reset in the middle of a burst, between clock edges
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h0500 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("arst_pre_valid", 32'(fif.o_r_valid), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    check("arst_count", 32'(fif.o_count), 32'd0);
    check("arst_empty", 32'(fif.o_empty), 32'd1);
    check("arst_valid", 32'(fif.o_r_valid), 32'd0);
    check("arst_data", 32'(fif.o_r_data), 32'd0);
    check("arst_ae", 32'(fif.o_almost_empty), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("arst_unf", 32'(fif.o_underflow), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
